mul_upper_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 2-bit upper-product multiplier (56x56, 3-cycle multi-cycle datapath, single-op-in-flight) among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time and drives the multiplier's one-cycle enable. It waits out the multiplier latency, then returns the 2-bit result tagged with the requester ID on a valid/ready response port. It sits between the reduction-stage clients and the shared multiplier instance.

---
 rtl/mul_upper_rr_arbiter.sv | 139 +++++++++++++
 tb/tb_mul_upper_rr_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_upper_rr_arbiter.sv
// Round-robin sequencer sharing one multi-cycle upper-product multiplier among NUM_REQ requesters.
// One op in flight: grant, pulse mul_en, wait MUL_LAT edges, hold the tagged result until taken.
module mul_upper_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int MUL_SIZE = 56,
    parameter int MUL_LAT  = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*MUL_SIZE-1:0]  req_a_i,
    input  logic [NUM_REQ*MUL_SIZE-1:0]  req_b_i,
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic [ID_W-1:0]              resp_id_o,
    output logic [1:0]                   resp_res_o,
    output logic                         mul_en_o,
    output logic [MUL_SIZE-1:0]          mul_a_o,
    output logic [MUL_SIZE-1:0]          mul_b_o,
    input  logic [1:0]                   mul_res_i,
    output logic                         busy_o
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      wcnt_q;
    logic [ID_W-1:0]       ptr_q;
    logic [ID_W-1:0]       grant;
    logic [ID_W-1:0]       idx;
    logic                  grant_vld;
    logic                  accept;
    logic                  wait_done;
    logic                  resp_valid_q;
    logic [ID_W-1:0]       resp_id_q;
    logic [1:0]            resp_res_q;
    logic                  mul_en_q;
    logic [MUL_SIZE-1:0]   mul_a_q;
    logic [MUL_SIZE-1:0]   mul_b_q;

    // First valid requester at or above ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant     = ptr_q;
        grant_vld = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_vld && req_valid_i[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

    assign accept    = (state_q == S_IDLE) && grant_vld;
    assign wait_done = (state_q == S_WAIT) && (wcnt_q == CNT_W'(MUL_LAT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)       state_d = S_START;
            S_START:                   state_d = S_WAIT;
            S_WAIT:  if (wait_done)    state_d = S_RESP;
            S_RESP:  if (resp_ready_i) state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        if ((state_q == S_IDLE) && grant_vld && !rst_i) begin
            req_ready_o[grant] = 1'b1;
        end
        busy_o = (state_q != S_IDLE);
    end

    // Operands change only on acceptance, so the multiplier never sees them move mid-op.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wcnt_q       <= '0;
            ptr_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_res_q   <= '0;
            mul_en_q     <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        mul_a_q   <= req_a_i[grant*MUL_SIZE +: MUL_SIZE];
                        mul_b_q   <= req_b_i[grant*MUL_SIZE +: MUL_SIZE];
                        resp_id_q <= grant;
                        mul_en_q  <= 1'b1;
                    end
                end
                S_START: begin
                    mul_en_q <= 1'b0;
                    wcnt_q   <= '0;
                end
                S_WAIT: begin
                    wcnt_q <= wcnt_q + 1'b1;
                    if (wait_done) begin
                        resp_res_q   <= mul_res_i;
                        resp_valid_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        ptr_q        <= (resp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : resp_id_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = resp_id_q;
    assign resp_res_o   = resp_res_q;
    assign mul_en_o     = mul_en_q;
    assign mul_a_o      = mul_a_q;
    assign mul_b_o      = mul_b_q;

endmodule

// File: tb/tb_mul_upper_rr_arbiter.sv
// Bench for mul_upper_rr_arbiter: behavioural multiplier, transaction-level reference model,
// directed scenarios followed by randomized traffic.
module tb_mul_upper_rr_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int MS = 56;
    localparam int ML = 3;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_ready_o;
    logic [N*MS-1:0]   req_a_i;
    logic [N*MS-1:0]   req_b_i;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic [IW-1:0]     resp_id_o;
    logic [1:0]        resp_res_o;
    logic              mul_en_o;
    logic [MS-1:0]     mul_a_o;
    logic [MS-1:0]     mul_b_o;
    logic [1:0]        mul_res_i;
    logic              busy_o;

    mul_upper_rr_arbiter #(.NUM_REQ(N), .ID_W(IW), .MUL_SIZE(MS), .MUL_LAT(ML)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_id_o(resp_id_o), .resp_res_o(resp_res_o),
        .mul_en_o(mul_en_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
        .mul_res_i(mul_res_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] up2(input logic [MS-1:0] a, input logic [MS-1:0] b);
        logic [2*MS-1:0] p;
        p = {{MS{1'b0}}, a} * {{MS{1'b0}}, b};
        return p[2*MS-1 -: 2];
    endfunction

    function automatic int rr(input int ptr, input logic [N-1:0] v);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (v[idx[IW-1:0]]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [MS-1:0] r56();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[MS-1:0];
    endfunction

    // Behavioural multiplier: result valid only during the cycle it is due, inverted otherwise.
    int        mm_cnt;
    logic [1:0] mm_p;
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mm_cnt <= 0;
            mm_p   <= 2'b00;
        end else if (mul_en_o) begin
            mm_cnt <= 1;
            mm_p   <= up2(mul_a_o, mul_b_o);
        end else if (mm_cnt != 0 && mm_cnt < 8) begin
            mm_cnt <= mm_cnt + 1;
        end
    end
    assign mul_res_i = (mm_cnt == ML) ? mm_p : ~mm_p;

    int rst_cnt = 0;
    initial forever begin
        @(posedge rst_i);
        rst_cnt++;
    end

    // Reference model: one transaction at a time, cycle offsets counted from the acceptance edge.
    initial begin : monitor
        int         rst_seen;
        bit         m_busy;
        int         m_cyc, m_id, m_ptr, g;
        logic [MS-1:0] m_a, m_b;
        logic [1:0] m_res;
        rst_seen = -1; m_busy = 0; m_ptr = 0; m_cyc = 0; m_id = 0;
        m_a = '0; m_b = '0; m_res = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i || rst_cnt != rst_seen) begin
                rst_seen = rst_cnt;
                m_busy   = 0;
                m_ptr    = 0;
            end
            if (!rst_i) begin
                if (!m_busy) begin
                    g = rr(m_ptr, req_valid_i);
                    check("req_ready", req_ready_o, (g >= 0) ? (128'd1 << g) : 128'd0);
                    check("idle_mul_en", mul_en_o, 0);
                    check("idle_busy", busy_o, 0);
                    check("idle_resp_valid", resp_valid_o, 0);
                    if (g >= 0) begin
                        m_busy = 1;
                        m_cyc  = 0;
                        m_id   = g;
                        m_a    = req_a_i[g*MS +: MS];
                        m_b    = req_b_i[g*MS +: MS];
                        m_res  = up2(m_a, m_b);
                    end
                end else begin
                    m_cyc++;
                    check("busy", busy_o, 1);
                    check("busy_req_ready", req_ready_o, 0);
                    check("mul_en", mul_en_o, (m_cyc == 1));
                    check("mul_a", mul_a_o, m_a);
                    check("mul_b", mul_b_o, m_b);
                    check("resp_valid", resp_valid_o, (m_cyc >= ML + 2));
                    if (m_cyc >= ML + 2) begin
                        check("resp_id", resp_id_o, m_id);
                        check("resp_res", resp_res_o, m_res);
                        if (resp_ready_i) begin
                            m_ptr  = (m_id + 1) % N;
                            m_busy = 0;
                        end
                    end
                end
            end
        end
    end

    logic [N-1:0]  pend;
    logic [MS-1:0] opa [N];
    logic [MS-1:0] opb [N];
    logic [N-1:0]  hs;
    int            cyc;
    int            acc_ids[$];
    int            acc_cyc[$];
    int            r_id[$];
    logic [1:0]    r_res[$];

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_a_i[i*MS +: MS] = opa[i];
            req_b_i[i*MS +: MS] = opb[i];
        end
        req_valid_i = pend;
    endtask

    task automatic present(input int i, input logic [MS-1:0] a, input logic [MS-1:0] b);
        pend[i] = 1'b1;
        opa[i]  = a;
        opb[i]  = b;
    endtask

    task automatic step();
        @(negedge clk_i);
        hs = req_ready_o & req_valid_i;
        if (resp_valid_o && resp_ready_i) begin
            r_id.push_back(int'(resp_id_o));
            r_res.push_back(resp_res_o);
        end
        @(posedge clk_i);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                pend[i] = 1'b0;
                acc_ids.push_back(i);
                acc_cyc.push_back(cyc);
            end
        end
        drive();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((pend != 0 || busy_o || resp_valid_o) && n < budget) begin
            step();
            n++;
        end
        check(tag, (n < budget), 1);
    endtask

    task automatic clear_logs();
        acc_ids.delete(); acc_cyc.delete(); r_id.delete(); r_res.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, req_ready_o, 0);
        check({tag, "_resp_valid"}, resp_valid_o, 0);
        check({tag, "_resp_id"}, resp_id_o, 0);
        check({tag, "_resp_res"}, resp_res_o, 0);
        check({tag, "_mul_en"}, mul_en_o, 0);
        check({tag, "_mul_a"}, mul_a_o, 0);
        check({tag, "_mul_b"}, mul_b_o, 0);
        check({tag, "_busy"}, busy_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [MS-1:0] ones, half;
        logic [IW-1:0] bp_id;
        logic [1:0]    bp_res;
        int            n;
        ones = '1;
        half = '0; half[MS-1] = 1'b1;
        cyc = 0;
        pend = '0;
        for (int i = 0; i < N; i++) present(i, r56(), r56());
        rst_i = 1'b1;
        resp_ready_i = 1'b1;
        drive();
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // All four valid out of reset.
        clear_logs();
        run_until_idle("simul_done", 100);
        check("simul_count", acc_ids.size(), 4);
        for (int k = 0; k < acc_ids.size(); k++) begin
            check("simul_order", acc_ids[k], k);
            if (k > 0) check("simul_gap", acc_cyc[k] - acc_cyc[k-1], 6);
        end
        for (int k = 0; k < r_id.size(); k++) check("simul_resp_id", r_id[k], k);

        // Fairness between requesters 0 and 3 with both continuously valid.
        clear_logs();
        present(0, r56(), r56());
        present(3, r56(), r56());
        drive();
        n = 0;
        while (acc_ids.size() < 8 && n < 200) begin
            step();
            n++;
            if (acc_ids.size() < 8) begin
                if (!pend[0]) present(0, r56(), r56());
                if (!pend[3]) present(3, r56(), r56());
                drive();
            end
        end
        check("fair_timeout", (n < 200), 1);
        run_until_idle("fair_done", 100);
        for (int k = 0; k < 8 && k < acc_ids.size(); k++)
            check("fair_order", acc_ids[k], (k % 2) ? 3 : 0);

        // Single request, a = b = 2^55.
        clear_logs();
        present(2, half, half);
        drive();
        run_until_idle("single_done", 50);
        check("single_resp_count", r_id.size(), 1);
        if (r_id.size() > 0) begin
            check("single_resp_id", r_id[0], 2);
            check("single_resp_res", r_res[0], 2'b01);
        end

        // All-ones operands; pointer sits at 3, so requester 3 goes before 1.
        clear_logs();
        present(1, ones, ones);
        present(3, ones, ones);
        drive();
        run_until_idle("ones_done", 50);
        check("ptr_after_single", (acc_ids.size() > 0) ? acc_ids[0] : -1, 3);
        for (int k = 0; k < r_res.size(); k++) check("ones_res", r_res[k], 2'b11);

        // Backpressure in RESP with other requests pending.
        clear_logs();
        resp_ready_i = 1'b0;
        present(0, r56(), r56());
        present(2, r56(), r56());
        drive();
        n = 0;
        while (!resp_valid_o && n < 20) begin
            step();
            n++;
        end
        check("bp_reach_resp", resp_valid_o, 1);
        bp_id  = resp_id_o;
        bp_res = resp_res_o;
        repeat (10) begin
            step();
            check("bp_valid", resp_valid_o, 1);
            check("bp_id", resp_id_o, bp_id);
            check("bp_res", resp_res_o, bp_res);
            check("bp_req_ready", req_ready_o, 0);
            check("bp_mul_en", mul_en_o, 0);
            check("bp_busy", busy_o, 1);
        end
        resp_ready_i = 1'b1;
        run_until_idle("bp_done", 100);

        // Randomized traffic with random response backpressure.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(3) == 0)) begin
                    case ($urandom_range(3))
                        0:       present(i, ones, ones);
                        1:       present(i, r56(), ones);
                        default: present(i, r56(), r56());
                    endcase
                end
            end
            resp_ready_i = ($urandom_range(3) != 0);
            drive();
            step();
        end
        resp_ready_i = 1'b1;
        run_until_idle("rand_done", 200);

        // Leave ptr at 3, then reset during WAIT with requester 1 in flight.
        present(2, r56(), r56());
        drive();
        run_until_idle("pre_rst_done", 50);
        clear_logs();
        present(1, r56(), r56());
        drive();
        n = 0;
        while (acc_ids.size() == 0 && n < 20) begin
            step();
            n++;
        end
        check("arst_accept", acc_ids.size(), 1);
        step();
        step();
        present(1, r56(), r56());
        present(3, r56(), r56());
        drive();
        #1 rst_i = 1'b1;
        #1 check_all_zero("arst");
        rst_i = 1'b0;
        clear_logs();
        run_until_idle("arst_done", 100);
        check("arst_reaccept", (acc_ids.size() > 0) ? acc_ids[0] : -1, 1);
        check("arst_resp_count", r_id.size(), 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
